// File: rtl/wbusixchar_pkg.sv
// Six-bit to printable-ASCII encoding constants and the pure encoder function.
package wbusixchar_pkg;

  localparam logic [7:0] CH_NEWLINE = 8'h0a;
  localparam logic [7:0] CH_AT      = 8'h40;
  localparam logic [7:0] CH_PCT     = 8'h25;
  localparam logic [7:0] CH_DIGIT   = 8'h30;  // '0'
  localparam logic [7:0] CH_UPPER   = 8'h41;  // 'A'
  localparam logic [7:0] CH_LOWER   = 8'h61;  // 'a'
  localparam logic [7:0] OFS_UPPER  = 8'd10;
  localparam logic [7:0] OFS_LOWER  = 8'd36;
  localparam logic [7:0] OFS_AT     = 8'd62;

  // bit6 requests a newline; otherwise the low six bits pick one of 64 symbols.
  function automatic logic [7:0] sixbit_to_ascii(input logic [6:0] bits);
    logic [7:0] v;
    logic [7:0] ch;
    v = {2'b00, bits[5:0]};
    if (bits[6])             ch = CH_NEWLINE;
    else if (v < OFS_UPPER)  ch = CH_DIGIT + v;
    else if (v < OFS_LOWER)  ch = CH_UPPER + (v - OFS_UPPER);
    else if (v < OFS_AT)     ch = CH_LOWER + (v - OFS_LOWER);
    else if (v == OFS_AT)    ch = CH_AT;
    else                     ch = CH_PCT;
    return ch;
  endfunction

endpackage

// File: rtl/wbusixchar_sfifo.sv
// Single-clock first-word-fallthrough FIFO: head word is visible combinationally
// whenever the FIFO is non-empty. Pointers carry one extra wrap bit.
module wbusixchar_sfifo #(
  parameter int LGFIFO = 4,
  parameter int W      = 7
) (
  input  logic            i_clk,
  input  logic            i_areset_n,
  input  logic            i_wr,
  input  logic [W-1:0]    i_data,
  input  logic            i_rd,
  output logic [W-1:0]    o_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [LGFIFO:0] o_fill
);

  localparam int DEPTH = 1 << LGFIFO;

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [LGFIFO:0] wr_q, wr_d, rd_q, rd_d;

  // Next-state for storage and pointers; caller never writes full or reads empty.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (i_wr) begin
      mem_d[wr_q[LGFIFO-1:0]] = i_data;
      wr_d = wr_q + (LGFIFO+1)'(1);
    end
    if (i_rd) rd_d = rd_q + (LGFIFO+1)'(1);
  end

  // Storage and pointer registers, all cleared by reset.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

  assign o_data  = mem_q[rd_q[LGFIFO-1:0]];
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[LGFIFO] != rd_q[LGFIFO]) &&
                   (wr_q[LGFIFO-1:0] == rd_q[LGFIFO-1:0]);
  assign o_fill  = wr_q - rd_q;

endmodule

// File: rtl/wbusixchar_fifo.sv
// Buffered six-bit-to-ASCII encoder for the debug-bus transmit path, with
// optional auto-newline after LINE_LEN chars and keepalive after idle time.
module wbusixchar_fifo
  import wbusixchar_pkg::*;
#(
  parameter int         LGFIFO      = 4,
  parameter int         LINE_LEN    = 0,
  parameter int         IDLE_CYCLES = 0,
  parameter logic [7:0] IDLE_CHAR   = 8'h2a
) (
  input  logic            i_clk,
  input  logic            i_areset_n,
  input  logic            i_stb,
  input  logic [6:0]      i_bits,
  output logic            o_busy,
  output logic            o_stb,
  output logic [7:0]      o_char,
  input  logic            i_busy,
  output logic [LGFIFO:0] o_fill,
  output logic            o_overflow
);

  logic [6:0]      fifo_head;
  logic            fifo_empty, fifo_full;
  logic [LGFIFO:0] fifo_fill;

  logic       accept, load, have_data, pop, byp, wr;
  logic [6:0] cand;
  logic       emit_vld;
  logic [7:0] emit_char;
  logic       line_full, ka_fire;

  logic       stb_q, stb_d;
  logic [7:0] char_q, char_d;
  logic       ovf_q, ovf_d;

  wbusixchar_sfifo #(.LGFIFO(LGFIFO), .W(7)) u_fifo (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_wr       (wr),
    .i_data     (i_bits),
    .i_rd       (pop),
    .o_data     (fifo_head),
    .o_empty    (fifo_empty),
    .o_full     (fifo_full),
    .o_fill     (fifo_fill)
  );

  // Output mux: pending newline, then FIFO head (or the incoming code when the
  // FIFO is empty, giving one-cycle latency), then keepalive.
  always_comb begin
    accept    = i_stb && !fifo_full;
    load      = !stb_q || !i_busy;
    have_data = !fifo_empty || accept;
    cand      = fifo_empty ? i_bits : fifo_head;
    emit_vld  = 1'b0;
    emit_char = char_q;
    pop       = 1'b0;
    byp       = 1'b0;
    if (load) begin
      if (have_data) begin
        emit_vld = 1'b1;
        if (line_full && !cand[6]) begin
          // Forced line break; the data code stays queued for next time.
          emit_char = CH_NEWLINE;
        end else begin
          emit_char = sixbit_to_ascii(cand);
          pop       = !fifo_empty;
          byp       = fifo_empty;
        end
      end else if (ka_fire) begin
        emit_vld  = 1'b1;
        emit_char = line_full ? CH_NEWLINE : IDLE_CHAR;
      end
    end
    wr     = accept && !byp;
    stb_d  = load ? emit_vld : stb_q;
    char_d = emit_char;
    ovf_d  = ovf_q || (i_stb && fifo_full);
  end

  // Output character register and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      stb_q  <= 1'b0;
      char_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      stb_q  <= stb_d;
      char_q <= char_d;
      ovf_q  <= ovf_d;
    end
  end

  generate
    if (LINE_LEN > 0) begin : g_line
      localparam int             LW   = $clog2(LINE_LEN + 1);
      localparam logic [LW-1:0]  LMAX = LW'(LINE_LEN);
      logic [LW-1:0] line_q, line_d;

      // Characters on the current line; any newline starts a fresh line.
      always_comb begin
        line_d = line_q;
        if (emit_vld) line_d = (emit_char == CH_NEWLINE) ? '0 : line_q + LW'(1);
      end

      // Line count register.
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) line_q <= '0;
        else             line_q <= line_d;
      end

      assign line_full = (line_q == LMAX);
    end else begin : g_no_line
      assign line_full = 1'b0;
    end

    if (IDLE_CYCLES > 0) begin : g_idle
      localparam int            IW    = $clog2(IDLE_CYCLES + 1);
      localparam logic [IW-1:0] IFIRE = IW'(IDLE_CYCLES - 1);
      logic [IW-1:0] idle_q, idle_d;
      logic          idle_cond;

      assign idle_cond = !stb_q && fifo_empty && !accept;
      // Fire on the cycle that completes the idle run so the keepalive is
      // presented right after IDLE_CYCLES silent cycles.
      assign ka_fire   = idle_cond && (idle_q == IFIRE);

      // Silent-cycle count; any accept or emission restarts it.
      always_comb begin
        idle_d = idle_q;
        if (accept || emit_vld) idle_d = '0;
        else if (idle_cond)     idle_d = idle_q + IW'(1);
      end

      // Idle count register.
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) idle_q <= '0;
        else             idle_q <= idle_d;
      end
    end else begin : g_no_idle
      assign ka_fire = 1'b0;
    end
  endgenerate

  assign o_busy     = fifo_full;
  assign o_stb      = stb_q;
  assign o_char     = char_q;
  assign o_fill     = fifo_fill;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_wbusixchar_fifo.sv
// Bench for wbusixchar_fifo: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model.
module tb_wbusixchar_fifo;

  localparam int LG    = 2;
  localparam int LL    = 4;
  localparam int IC    = 8;
  localparam int DEPTH = 1 << LG;

  logic          i_clk = 1'b0;
  logic          i_areset_n = 1'b0;
  logic          i_stb = 1'b0;
  logic [6:0]    i_bits = '0;
  logic          i_busy = 1'b0;
  logic          o_busy, o_stb, o_overflow;
  logic [7:0]    o_char;
  logic [LG:0]   o_fill;

  always #5 i_clk = ~i_clk;

  wbusixchar_fifo #(.LGFIFO(LG), .LINE_LEN(LL), .IDLE_CYCLES(IC), .IDLE_CHAR(8'h2a)) dut (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_stb      (i_stb),
    .i_bits     (i_bits),
    .o_busy     (o_busy),
    .o_stb      (o_stb),
    .o_char     (o_char),
    .i_busy     (i_busy),
    .o_fill     (o_fill),
    .o_overflow (o_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [6:0] mq[$];
  logic       m_stb;
  logic [7:0] m_char;
  int         m_line;
  int         m_idle;
  logic       m_ovf;
  string      alpha;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(input logic [6:0] code);
    if (code[6]) return 8'h0a;
    return alpha[int'(code[5:0])];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stb  = 1'b0;
    m_char = 8'h00;
    m_line = 0;
    m_idle = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock of the reference: arriving code joins the queue tail, the
  // output slot takes a line break, the queue head, or a keepalive.
  task automatic model_step(input logic s, input logic [6:0] b, input logic bz);
    bit         acc, idle_ok, emitted;
    logic [7:0] c;
    logic [6:0] h;
    acc     = s && (mq.size() < DEPTH);
    if (s && !acc) m_ovf = 1'b1;
    idle_ok = !m_stb && (mq.size() == 0) && !acc;
    if (acc) mq.push_back(b);
    emitted = 1'b0;
    c       = 8'h00;
    if (!m_stb || !bz) begin
      if (mq.size() > 0) begin
        emitted = 1'b1;
        h = mq[0];
        if (m_line == LL && !h[6]) c = 8'h0a;
        else begin
          c = ref_char(h);
          void'(mq.pop_front());
        end
      end else if (idle_ok && m_idle == IC - 1) begin
        emitted = 1'b1;
        c = (m_line == LL) ? 8'h0a : 8'h2a;
      end
      m_stb = emitted;
      if (emitted) m_char = c;
    end
    if (emitted) m_line = (c == 8'h0a) ? 0 : m_line + 1;
    if (acc || emitted) m_idle = 0;
    else if (idle_ok)   m_idle++;
  endtask

  task automatic check_outputs();
    chk("stb", 32'(o_stb), 32'(m_stb));
    if (m_stb) chk("char", 32'(o_char), 32'(m_char));
    chk("fill", 32'(o_fill), 32'(mq.size()));
    chk("busy", 32'(o_busy), 32'(mq.size() == DEPTH));
    chk("ovf", 32'(o_overflow), 32'(m_ovf));
  endtask

  // Drive one cycle: inputs set just after the edge, outputs compared, then clock.
  task automatic cyc(input logic s, input logic [6:0] b, input logic bz);
    i_stb  = s;
    i_bits = b;
    i_busy = bz;
    #1;
    check_outputs();
    model_step(s, b, bz);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 7'h00, 1'b0);
  endtask

  // Offer a code only when the model says there is room, bounded wait.
  task automatic send(input logic [6:0] code);
    bit sent;
    sent = 1'b0;
    for (int t = 0; t < 50 && !sent; t++) begin
      if (mq.size() < DEPTH) begin
        cyc(1'b1, code, 1'b0);
        sent = 1'b1;
      end else begin
        cyc(1'b0, 7'h00, 1'b0);
      end
    end
    chk("send_timeout", 32'(sent), 32'd1);
  endtask

  // Asynchronous reset pulse asserted away from the clock edge.
  task automatic do_reset();
    i_stb = 1'b0;
    i_areset_n = 1'b0;
    #1;
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_char", 32'(o_char), 32'd0);
    chk("rst_fill", 32'(o_fill), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_areset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    alpha = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz@%";
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset();

    // Keepalive cadence from reset, then an accept on the firing cycle.
    idle(30);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (m_idle == IC - 1) found = 1'b1;
      else cyc(1'b0, 7'h00, 1'b0);
    end
    chk("ka_phase", 32'(found), 32'd1);
    cyc(1'b1, 7'd5, 1'b0);
    idle(3);

    // Reset mid-stream with a stalled, full FIFO.
    for (int k = 0; k < 5; k++) cyc(1'b1, 7'(k + 1), 1'b1);
    cyc(1'b0, 7'h00, 1'b1);
    chk("pre_rst_full", 32'(o_busy), 32'd1);
    do_reset();
    idle(4);

    // Auto-newline: ABCD, forced break, E.
    for (int k = 10; k <= 14; k++) send(7'(k));
    idle(3);
    do_reset();
    // Explicit newline at line end is emitted once.
    for (int k = 0; k < 4; k++) send(7'(k + 20));
    send(7'h40);
    idle(4);

    // Full alphabet plus explicit newline.
    do_reset();
    for (int v = 0; v < 64; v++) send(7'(v));
    send(7'h40);
    idle(10);

    // Back-pressure and overflow: 1 presented + 4 queued, 6th dropped.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, 7'(30 + k), 1'b1);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    idle(8);

    // Simultaneous accept and pop at fill=2.
    do_reset();
    cyc(1'b1, 7'd1, 1'b1);
    cyc(1'b1, 7'd2, 1'b1);
    cyc(1'b1, 7'd3, 1'b1);
    cyc(1'b1, 7'd4, 1'b0);
    chk("fill_hold", 32'(o_fill), 32'd2);
    idle(6);

    // Random traffic in blocks of varying input density and stall rate.
    do_reset();
    for (int blk = 0; blk < 40; blk++) begin
      int dens, stall;
      dens  = int'($urandom_range(0, 4));
      stall = int'($urandom_range(0, 3));
      if (blk == 20) do_reset();
      for (int k = 0; k < 60; k++) begin
        logic s, bz;
        s  = (int'($urandom_range(1, 4)) <= dens);
        bz = (int'($urandom_range(0, 3)) < stall);
        cyc(s, 7'($urandom), bz);
      end
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
